// File: rtl/bin_pkg.sv
// rtl/bin_pkg.sv - shared constants, state encoding and clamp helper for the bin loader
package bin_pkg;

    localparam int NUM_DEF        = 8;
    localparam int WIDTH_DEF      = 5;
    localparam int ADDR_WIDTH_DEF = 9;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } state_t;

    function automatic int unsigned min_num(input int unsigned num, input int unsigned lim);
        return (num > lim) ? lim : num;
    endfunction

endpackage

// File: rtl/bin_load_scatter_ctrl_if.sv
// rtl/bin_load_scatter_ctrl_if.sv - command, bin RAM and scatter-stage signals of the loader
interface bin_load_scatter_ctrl_if
    import bin_pkg::*;
#(
    parameter int NUM        = NUM_DEF,
    parameter int WIDTH      = WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
);
    localparam int CNT_WIDTH = $clog2(NUM) + 1;

    logic                  start_i;
    logic [ADDR_WIDTH-1:0] base_addr_i;
    logic [CNT_WIDTH-1:0]  num_i;
    logic                  hold_i;
    logic                  ram_rd_en_o;
    logic [ADDR_WIDTH-1:0] ram_addr_o;
    logic [WIDTH-1:0]      ram_data_i;
    logic [NUM-1:0]        wr_o;
    logic [WIDTH-1:0]      data_o;
    logic                  busy_o;
    logic                  done_o;

    modport master (
        output start_i, base_addr_i, num_i, hold_i, ram_data_i,
        input  ram_rd_en_o, ram_addr_o, wr_o, data_o, busy_o, done_o
    );

    modport slave (
        input  start_i, base_addr_i, num_i, hold_i, ram_data_i,
        output ram_rd_en_o, ram_addr_o, wr_o, data_o, busy_o, done_o
    );

endinterface

// File: rtl/idx_to_onehot.sv
// rtl/idx_to_onehot.sv - slot index to one-hot strobe decode with enable
module idx_to_onehot #(
    parameter int NUM = 8,
    localparam int IW = $clog2(NUM)
) (
    input  logic           en,
    input  logic [IW-1:0]  idx,
    output logic [NUM-1:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/bin_load_scatter_ctrl.sv
// rtl/bin_load_scatter_ctrl.sv - reads up to NUM consecutive bin RAM words and strobes them
// into scatter slots 0..n-1 in order
module bin_load_scatter_ctrl
    import bin_pkg::*;
#(
    parameter int NUM        = NUM_DEF,
    parameter int WIDTH      = WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input logic                   clk,
    input logic                   rst,
    bin_load_scatter_ctrl_if.slave bus
);

    localparam int CNT_WIDTH = $clog2(NUM) + 1;
    localparam int TAG_WIDTH = $clog2(NUM);

    typedef logic [CNT_WIDTH-1:0] cnt_t;

    localparam cnt_t CNT_ONE = cnt_t'(1);

    state_t                state;
    cnt_t                  idx;
    cnt_t                  count;
    cnt_t                  num_clamped;
    logic [ADDR_WIDTH-1:0] base;
    logic [TAG_WIDTH-1:0]  tag;
    logic [TAG_WIDTH-1:0]  tag1;
    logic                  v1;
    logic [NUM-1:0]        wr_next;

    assign num_clamped = cnt_t'(min_num(32'(bus.num_i), NUM));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            idx             <= '0;
            count           <= '0;
            base            <= '0;
            tag             <= '0;
            bus.ram_rd_en_o <= 1'b0;
            bus.ram_addr_o  <= '0;
            bus.busy_o      <= 1'b0;
            bus.done_o      <= 1'b0;
        end else begin
            bus.done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start_i) begin
                        if (num_clamped == '0) begin
                            bus.done_o <= 1'b1;
                        end else begin
                            base       <= bus.base_addr_i;
                            count      <= num_clamped;
                            idx        <= '0;
                            bus.busy_o <= 1'b1;
                            state      <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (bus.hold_i) begin
                        bus.ram_rd_en_o <= 1'b0;
                    end else begin
                        bus.ram_rd_en_o <= 1'b1;
                        bus.ram_addr_o  <= base + ADDR_WIDTH'(idx);
                        tag             <= idx[TAG_WIDTH-1:0];
                        idx             <= idx + CNT_ONE;
                        if (idx + CNT_ONE == count) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    bus.ram_rd_en_o <= 1'b0;
                    // Last read has left both pipeline stages once rd_en and v1 are both low.
                    if (!bus.ram_rd_en_o && !v1) begin
                        state      <= IDLE;
                        bus.busy_o <= 1'b0;
                        bus.done_o <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    idx_to_onehot #(.NUM(NUM)) u_dec (
        .en     (v1),
        .idx    (tag1),
        .onehot (wr_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1         <= 1'b0;
            tag1       <= '0;
            bus.wr_o   <= '0;
            bus.data_o <= '0;
        end else begin
            v1         <= bus.ram_rd_en_o;
            tag1       <= tag;
            bus.wr_o   <= wr_next;
            bus.data_o <= v1 ? bus.ram_data_i : '0;
        end
    end

endmodule

// File: tb/tb_bin_load_scatter_ctrl.sv
// tb/tb_bin_load_scatter_ctrl.sv - table-driven and directed checks of bin_load_scatter_ctrl
module tb_bin_load_scatter_ctrl;

    typedef struct packed {
        logic [8:0]      base;
        logic [3:0]      num;
        logic [7:0]      hold_from;
        logic [7:0]      hold_to;
        logic [3:0]      exp_n;
        logic [7:0]      exp_done;
        logic [7:0]      exp_busy_last;
        logic [7:0][7:0] exp_wr;
        logic [7:0][7:0] exp_rd;
    } vec_t;

    typedef struct packed {
        int         cyc;
        logic [7:0] wr;
        logic [4:0] data;
    } wr_ev_t;

    typedef struct packed {
        int         cyc;
        logic [8:0] addr;
    } rd_ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    bin_load_scatter_ctrl_if #(.NUM(8), .WIDTH(5), .ADDR_WIDTH(9)) bus ();

    bin_load_scatter_ctrl #(.NUM(8), .WIDTH(5), .ADDR_WIDTH(9)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [4:0] mem [512];
    always @(posedge clk) begin
        if (bus.ram_rd_en_o) bus.ram_data_i <= mem[bus.ram_addr_o];
    end

    int n_assert = 0;
    int n_fail   = 0;
    int edge_cnt = 0;
    int c0       = 0;
    bit mon_en   = 1'b0;

    wr_ev_t wr_q[$];
    rd_ev_t rd_q[$];
    int     done_q[$];
    int     busy_first, busy_last, busy_cnt, data_bad;

    vec_t vecs[6];

    always @(posedge clk) edge_cnt++;

    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.ram_rd_en_o) rd_q.push_back('{edge_cnt - c0, bus.ram_addr_o});
            if (bus.wr_o != '0) wr_q.push_back('{edge_cnt - c0, bus.wr_o, bus.data_o});
            else if (bus.data_o != '0) data_bad++;
            if (bus.done_o) done_q.push_back(edge_cnt - c0);
            if (bus.busy_o) begin
                if (busy_cnt == 0) busy_first = edge_cnt - c0;
                busy_last = edge_cnt - c0;
                busy_cnt++;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_assert++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic clear_mon();
        wr_q.delete();
        rd_q.delete();
        done_q.delete();
        busy_first = 0;
        busy_last  = 0;
        busy_cnt   = 0;
        data_bad   = 0;
    endtask

    function automatic vec_t mk(input logic [8:0] base, input logic [3:0] num,
                                input int hf, input int ht, input int n,
                                input int done, input int bl);
        vec_t r;
        r.base          = base;
        r.num           = num;
        r.hold_from     = 8'(hf);
        r.hold_to       = 8'(ht);
        r.exp_n         = 4'(n);
        r.exp_done      = 8'(done);
        r.exp_busy_last = 8'(bl);
        for (int k = 0; k < 8; k++) begin
            r.exp_wr[k] = 8'(4 + k);
            r.exp_rd[k] = 8'(2 + k);
        end
        return r;
    endfunction

    task automatic run_load(input vec_t v, input int id);
        string tag;
        int    n;
        tag = $sformatf("v%0d", id);
        clear_mon();
        @(posedge clk); #1;
        c0 = edge_cnt;
        bus.start_i     = 1'b1;
        bus.base_addr_i = v.base;
        bus.num_i       = v.num;
        mon_en          = 1'b1;
        for (int c = 0; c < 20; c++) begin
            bus.hold_i = (c >= int'(v.hold_from) && c <= int'(v.hold_to));
            @(posedge clk); #1;
            bus.start_i = 1'b0;
        end
        bus.hold_i = 1'b0;
        mon_en     = 1'b0;
        chk({tag, "_n_writes"}, wr_q.size(), int'(v.exp_n));
        chk({tag, "_n_reads"}, rd_q.size(), int'(v.exp_n));
        n = (wr_q.size() < 8) ? wr_q.size() : 8;
        for (int k = 0; k < n; k++) begin
            chk($sformatf("%s_wr%0d_strobe", tag, k), int'(wr_q[k].wr), 1 << k);
            chk($sformatf("%s_wr%0d_data", tag, k), int'(wr_q[k].data),
                int'(mem[9'(int'(v.base) + k)]));
            chk($sformatf("%s_wr%0d_cycle", tag, k), wr_q[k].cyc, int'(v.exp_wr[k]));
        end
        n = (rd_q.size() < 8) ? rd_q.size() : 8;
        for (int k = 0; k < n; k++) begin
            chk($sformatf("%s_rd%0d_addr", tag, k), int'(rd_q[k].addr), (int'(v.base) + k) % 512);
            chk($sformatf("%s_rd%0d_cycle", tag, k), rd_q[k].cyc, int'(v.exp_rd[k]));
        end
        chk({tag, "_n_done"}, done_q.size(), 1);
        if (done_q.size() > 0) chk({tag, "_done_cycle"}, done_q[0], int'(v.exp_done));
        chk({tag, "_busy_cycles"}, busy_cnt, int'(v.exp_busy_last));
        if (v.exp_busy_last != 0) begin
            chk({tag, "_busy_first"}, busy_first, 1);
            chk({tag, "_busy_last"}, busy_last, int'(v.exp_busy_last));
        end
        chk({tag, "_data_zero_when_idle"}, data_bad, 0);
    endtask

    initial begin
        for (int a = 0; a < 512; a++) mem[a] = 5'(a + 1 - 16);
        bus.start_i     = 1'b0;
        bus.base_addr_i = '0;
        bus.num_i       = '0;
        bus.hold_i      = 1'b0;

        vecs[0] = mk(9'h010, 4'd8,  1, 0, 8, 12, 11);
        vecs[1] = mk(9'h000, 4'd0,  1, 0, 0,  1,  0);
        vecs[2] = mk(9'h020, 4'd12, 1, 0, 8, 12, 11);
        vecs[3] = mk(9'h1FE, 4'd4,  1, 0, 4,  8,  7);
        vecs[4] = mk(9'h030, 4'd3,  2, 3, 3,  9,  8);
        vecs[4].exp_wr[1] = 8'd7;
        vecs[4].exp_wr[2] = 8'd8;
        vecs[4].exp_rd[1] = 8'd5;
        vecs[4].exp_rd[2] = 8'd6;
        vecs[5] = mk(9'h050, 4'd1,  1, 0, 1,  5,  4);

        repeat (3) @(posedge clk);
        #1;
        chk("reset_rd_en", int'(bus.ram_rd_en_o), 0);
        chk("reset_addr", int'(bus.ram_addr_o), 0);
        chk("reset_wr", int'(bus.wr_o), 0);
        chk("reset_data", int'(bus.data_o), 0);
        chk("reset_busy", int'(bus.busy_o), 0);
        chk("reset_done", int'(bus.done_o), 0);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) run_load(vecs[i], i);

        // Second start mid-load is dropped; a start in the done cycle is taken.
        clear_mon();
        @(posedge clk); #1;
        c0 = edge_cnt;
        mon_en = 1'b1;
        for (int c = 0; c < 16; c++) begin
            bus.start_i = (c == 0 || c == 3 || c == 6);
            bus.base_addr_i = (c == 3) ? 9'h040 : (c == 6) ? 9'h070 : 9'h060;
            bus.num_i = (c == 6) ? 4'd1 : 4'd2;
            if (c == 6) chk("ign_done_at_restart", int'(bus.done_o), 1);
            if (c == 7) chk("ign_busy_after_restart", int'(bus.busy_o), 1);
            @(posedge clk); #1;
        end
        bus.start_i = 1'b0;
        mon_en = 1'b0;
        chk("ign_n_writes", wr_q.size(), 3);
        if (wr_q.size() == 3) begin
            chk("ign_wr0_cycle", wr_q[0].cyc, 4);
            chk("ign_wr0_data", int'(wr_q[0].data), int'(mem[9'h060]));
            chk("ign_wr1_strobe", int'(wr_q[1].wr), 2);
            chk("ign_wr1_data", int'(wr_q[1].data), int'(mem[9'h061]));
            chk("ign_wr2_cycle", wr_q[2].cyc, 10);
            chk("ign_wr2_strobe", int'(wr_q[2].wr), 1);
            chk("ign_wr2_data", int'(wr_q[2].data), int'(mem[9'h070]));
        end
        chk("ign_n_reads", rd_q.size(), 3);
        if (rd_q.size() == 3) chk("ign_rd2_addr", int'(rd_q[2].addr), 9'h070);
        chk("ign_n_done", done_q.size(), 2);
        if (done_q.size() == 2) begin
            chk("ign_done0_cycle", done_q[0], 6);
            chk("ign_done1_cycle", done_q[1], 11);
        end
        chk("ign_busy_cycles", busy_cnt, 9);

        // Reset in cycle 5 of an 8-word load.
        @(posedge clk); #1;
        c0 = edge_cnt;
        bus.start_i     = 1'b1;
        bus.base_addr_i = 9'h010;
        bus.num_i       = 4'd8;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            bus.start_i = 1'b0;
        end
        chk("rstmid_wr_before", int'(bus.wr_o), 2);
        rst = 1'b1;
        #1;
        chk("rstmid_wr", int'(bus.wr_o), 0);
        chk("rstmid_data", int'(bus.data_o), 0);
        chk("rstmid_rd_en", int'(bus.ram_rd_en_o), 0);
        chk("rstmid_addr", int'(bus.ram_addr_o), 0);
        chk("rstmid_busy", int'(bus.busy_o), 0);
        chk("rstmid_done", int'(bus.done_o), 0);
        clear_mon();
        mon_en = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        mon_en = 1'b0;
        chk("rstmid_no_writes", wr_q.size(), 0);
        chk("rstmid_no_reads", rd_q.size(), 0);
        chk("rstmid_no_done", done_q.size(), 0);
        chk("rstmid_no_busy", busy_cnt, 0);

        run_load(vecs[0], 6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/bin_load_scatter_ctrl.md
Name: bin_load_scatter_ctrl

Overview:
Sequential loader directly upstream of the 8-slot scatter stage in the bin manager. On a start command it reads `num_i` consecutive words from the synchronous bin RAM, beginning at `base_addr_i`. For each returned word it emits one registered `data_o` plus a one-hot `wr_o` selecting the destination slot (slot k receives word k). The `wr_o`/`data_o` pair feeds the scatter stage's `wr_i`/`data_i` unchanged; `done_o` tells the bin manager FSM that the load is complete.

Parameters:
- NUM, 8, number of destination slots (power of two, ≥2).
- WIDTH, 5, data word width.
- ADDR_WIDTH, 9, bin RAM address width.
- CNT_WIDTH, $clog2(NUM)+1, width of `num_i` (localparam; holds values 0..NUM).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start_i  in  1  load request; sampled only in IDLE.
- base_addr_i  in  ADDR_WIDTH  first RAM address; latched on accepted start.
- num_i  in  CNT_WIDTH  words to load; latched on accepted start; values >NUM are clamped to NUM.
- hold_i  in  1  stall; suppresses issue of new RAM reads.
- ram_rd_en_o  out  1  registered RAM read enable.
- ram_addr_o  out  ADDR_WIDTH  registered RAM address.
- ram_data_i  in  WIDTH  RAM read data; valid the cycle after `ram_rd_en_o`=1.
- wr_o  out  NUM  registered one-hot slot write strobe.
- data_o  out  WIDTH  registered word; 0 whenever `wr_o`==0.
- busy_o  out  1  load in progress.
- done_o  out  1  one-cycle completion pulse.

Behaviour:
- Reset (async, active-high): all outputs 0; state IDLE; idx, count, base and pipeline-valid bits cleared.
- Reset mid-load: the load is abandoned immediately; no further `wr_o`, no `done_o`.
- States:
  - IDLE:
    - `start_i` with clamped n≥1: latch base and n, set idx=0, go to ISSUE.
    - `start_i` with n=0: `done_o`=1 next cycle, stay in IDLE.
  - ISSUE, each edge with `hold_i`=0: `ram_rd_en_o`<=1, `ram_addr_o`<=(base+idx) mod 2^ADDR_WIDTH, tag<=idx, idx<=idx+1. The edge that issues idx=n-1 moves to DRAIN.
  - ISSUE, edge with `hold_i`=1: `ram_rd_en_o`<=0; idx, address and tag unchanged.
  - DRAIN: `ram_rd_en_o`<=0. Wait until both pipeline valid bits are 0, then go to IDLE, assert `done_o`=1 for one cycle, drop `busy_o`.
- Return pipeline:
  - v1<=`ram_rd_en_o`, tag1<=tag.
  - On the next edge: `wr_o`<=v1 ? onehot(tag1) : 0, and `data_o`<=v1 ? `ram_data_i` : 0.
- Timing, with start sampled at the end of cycle 0 and no stalls:
  - State is ISSUE in cycle 1.
  - `ram_rd_en_o` is high in cycles 2..n+1.
  - `wr_o` for slot k is high in cycle 4+k.
  - `done_o` is high in cycle n+4.
  - `busy_o` is high in cycles 1..n+3.
- Hold: affects issue only. Reads already in flight still complete and produce `wr_o`. Each stall cycle delays all later events by one cycle.
- `start_i` while `busy_o`=1 is ignored; there is no queueing.
- `wr_o` is at most one-hot, and each slot 0..n-1 is written exactly once per load, in ascending order.
- Address wrap: base+idx past 2^ADDR_WIDTH-1 wraps to 0.

Decomposition:
- Shared package `bin_pkg`:
  - Default slot count, word width and bin address width constants.
  - State enum {IDLE, ISSUE, DRAIN}.
  - Clamp helper `min(num, NUM)`.
- Sub-module `idx_to_onehot` (parameter NUM): combinational idx → one-hot decode, with an enable input that forces all-zero output.

Test Plan:
- Basic load: RAM[0x10+k]=k+1, start with base=0x10, num=8 → `wr_o`=0x01..0x80 in cycles 4..11, `data_o`=1..8, `done_o` in cycle 12, `busy_o` in cycles 1..11.
- Edge counts:
  - num=0 → `done_o` in cycle 1 only; `ram_rd_en_o`, `wr_o` and `busy_o` never high.
  - num=12 → clamped: exactly 8 writes.
- Wrap: base=0x1FE, num=4 → addresses 0x1FE, 0x1FF, 0x000, 0x001; slots 0..3 get RAM at those addresses.
- Stall: num=3, `hold_i`=1 during cycles 2..3 → addresses issued in cycles 2, 5, 6; `wr_o` 0x1, 0x2, 0x4 in cycles 4, 7, 8; `done_o` in cycle 9.
- Ignored start: second `start_i` with base=0x40 in cycle 3 of a num=2 load → only the first load's 2 writes occur; `busy_o` falls, and the next start is accepted after `done_o`.
- Reset mid-load: assert `rst` in cycle 5 of a num=8 load → all outputs 0 asynchronously; no `done_o`. A load started after release runs exactly as in the basic load.
